// File: rtl/usb_tx_pkg.sv
// Shared types and line codes for the USB transmit line encoder.
// Build macro USB_TX_LOW_SPEED_EN selects low-speed J/K polarity.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  // Line codes are {dplus, dminus}
`ifdef USB_TX_LOW_SPEED_EN
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
`else
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
`endif
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

  // NRZI level: 0 = J, 1 = K
  function automatic logic [1:0] line_code(input logic level);
    return level ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time tick generator: one tick every CLKS_PER_BIT enabled clocks,
// with a synchronous restart that realigns the bit boundary.
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count;

  assign bit_tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_tick ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: double-buffered LSB-first serializer with bit
// stuffing, NRZI and EOP generation. Macro USB_TX_LOW_SPEED_EN swaps J/K.
module usb_tx_line_encoder #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  input  logic       eop_req,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_overrun,
  output logic       dplus,
  output logic       dminus
);
  import usb_tx_pkg::*;

  tx_state_t  state;
  logic       hold_valid;
  logic [7:0] hold_byte;
  logic [6:0] shreg;
  logic [3:0] shift_count;
  logic [2:0] ones_count;
  logic       eop_pending;
  logic       nrzi_level;
  logic [1:0] se0_count;
  logic       bit_tick;

  logic       load_ok, byte_avail, eop_any, stuff_due, byte_end, take_byte, idle_start;
  logic [7:0] byte_src;
  logic       ld_level, db_level;
  logic [2:0] ld_ones, db_ones;

  assign tx_ready = !hold_valid;
  assign tx_busy  = (state != IDLE);

  // A byte offered while the line is free bypasses the holding register so
  // its first bit is on the line the cycle after the load.
  always_comb begin
    load_ok    = tx_load && !hold_valid;
    byte_avail = hold_valid || load_ok;
    byte_src   = hold_valid ? hold_byte : tx_byte;
    eop_any    = eop_pending || eop_req;
    stuff_due  = (state == SHIFT) && (ones_count == STUFF_LIMIT);
    byte_end   = bit_tick && (((state == SHIFT) && !stuff_due) || (state == STUFF))
                 && (shift_count == 4'd8);
    take_byte  = byte_avail && ((state == IDLE) || byte_end);
    idle_start = (state == IDLE) && (byte_avail || eop_any);
    ld_level   = byte_src[0] ? nrzi_level : ~nrzi_level;
    ld_ones    = byte_src[0] ? ones_count + 3'd1 : '0;
    db_level   = shreg[0] ? nrzi_level : ~nrzi_level;
    db_ones    = shreg[0] ? ones_count + 3'd1 : '0;
  end

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .enable   (tx_busy),
    .restart  (idle_start),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      hold_valid       <= 1'b0;
      hold_byte        <= '0;
      shreg            <= '0;
      shift_count      <= '0;
      ones_count       <= '0;
      eop_pending      <= 1'b0;
      nrzi_level       <= 1'b0;
      se0_count        <= '0;
      tx_overrun       <= 1'b0;
      {dplus, dminus}  <= LINE_J;
    end else begin
      tx_overrun <= tx_load && hold_valid;

      if (take_byte) begin
        hold_valid <= 1'b0;
      end else if (load_ok) begin
        hold_valid <= 1'b1;
        hold_byte  <= tx_byte;
      end

      if (eop_req) eop_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (byte_avail) begin
            state           <= SHIFT;
            shreg           <= byte_src[7:1];
            shift_count     <= 4'd1;
            nrzi_level      <= ld_level;
            ones_count      <= ld_ones;
            {dplus, dminus} <= line_code(ld_level);
          end else if (eop_any) begin
            state           <= EOP_SE0;
            se0_count       <= '0;
            {dplus, dminus} <= LINE_SE0;
          end
        end

        SHIFT, STUFF: begin
          if (bit_tick) begin
            if (stuff_due) begin
              state           <= STUFF;
              nrzi_level      <= ~nrzi_level;
              ones_count      <= '0;
              {dplus, dminus} <= line_code(~nrzi_level);
            end else if (shift_count != 4'd8) begin
              state           <= SHIFT;
              shreg           <= {1'b0, shreg[6:1]};
              shift_count     <= shift_count + 4'd1;
              nrzi_level      <= db_level;
              ones_count      <= db_ones;
              {dplus, dminus} <= line_code(db_level);
            end else if (byte_avail) begin
              state           <= SHIFT;
              shreg           <= byte_src[7:1];
              shift_count     <= 4'd1;
              nrzi_level      <= ld_level;
              ones_count      <= ld_ones;
              {dplus, dminus} <= line_code(ld_level);
            end else if (eop_any) begin
              state           <= EOP_SE0;
              se0_count       <= '0;
              {dplus, dminus} <= LINE_SE0;
            end else begin
              state           <= IDLE;
              nrzi_level      <= 1'b0;
              ones_count      <= '0;
              {dplus, dminus} <= LINE_J;
            end
          end
        end

        EOP_SE0: begin
          if (bit_tick) begin
            if (se0_count == EOP_SE0_BITS - 2'd1) begin
              state           <= EOP_J;
              {dplus, dminus} <= LINE_J;
            end else begin
              se0_count <= se0_count + 2'd1;
            end
          end
        end

        EOP_J: begin
          if (bit_tick) begin
            state       <= IDLE;
            eop_pending <= 1'b0;
            nrzi_level  <= 1'b0;
            ones_count  <= '0;
          end
        end

        default: begin
          state           <= IDLE;
          {dplus, dminus} <= LINE_J;
        end
      endcase
    end
  end

endmodule
